// File: rtl/fetch_align_buffer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_align_buffer_pkg
// Shared definitions for the fetch align buffer:
//   - default address width, PC_PLUS width and reset PC
//   - PC_PLUS codes consumed by the NextPC selector
//   - result record of one instruction extractor
//   - helper that turns a consumed halfword count into a PC_PLUS code
// -----------------------------------------------------------------------------
package fetch_align_buffer_pkg;

   localparam int          ADDR_WIDTH    = 32'sd32;
   localparam int          PC_PLUS_WIDTH = 32'sd3;
   localparam logic [31:0] START_PC      = 32'h8000_0000;

   // Queue geometry: 8 halfwords, one beat carries 4.
   localparam int          QUEUE_DEPTH   = 32'sd8;
   localparam int          HW_PER_BEAT   = 32'sd4;

   typedef enum logic [2:0] {
      PC_PLUS_0 = 3'd0,
      PC_PLUS_2 = 3'd1,
      PC_PLUS_4 = 3'd2,
      PC_PLUS_6 = 3'd3,
      PC_PLUS_8 = 3'd4
   } pc_plus_e;

   // One extracted instruction: zero-extended word, presentable flag,
   // length in halfwords (1 = RVC, 2 = 32-bit).
   typedef struct packed {
      logic [31:0] inst;
      logic        valid;
      logic [1:0]  len;
   } extract_t;

   // Halfwords consumed this cycle (0..4) -> PC_PLUS code.
   function automatic pc_plus_e pc_plus_encode(input logic [2:0] hw_count);
      pc_plus_e code;
      case (hw_count)
         3'd0:    code = PC_PLUS_0;
         3'd1:    code = PC_PLUS_2;
         3'd2:    code = PC_PLUS_4;
         3'd3:    code = PC_PLUS_6;
         3'd4:    code = PC_PLUS_8;
         default: code = PC_PLUS_0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/fetch_align_buffer_extract.sv
// -----------------------------------------------------------------------------
// align_extract
// Decodes the length of the instruction starting at the first halfword of a
// 4-halfword window and reports whether all of its halfwords are present.
// Ports:
//   win_i      4-halfword window, win_i[0] is the instruction start
//   avail_i    number of valid halfwords from win_i[0] onward (0..8)
//   extract_o  {inst (RVC zero-extended), valid, len in halfwords}
// -----------------------------------------------------------------------------
module align_extract
   import fetch_align_buffer_pkg::*;
(
   input  logic [3:0][15:0] win_i,
   input  logic [3:0]       avail_i,
   output extract_t         extract_o
);

   logic is_wide_s;
   // Only the first two halfwords can belong to an RV32IC instruction; the
   // rest of the window is folded here so the interface keeps its full width.
   logic unused_window_tail_s;

   assign unused_window_tail_s = ^{win_i[3], win_i[2]};

   // Length decode and completeness check of the instruction at win_i[0].
   always_comb begin
      extract_o = '0;
      is_wide_s = (win_i[0][1:0] == 2'b11);
      if (is_wide_s) begin
         extract_o.inst = {win_i[1], win_i[0]};
         extract_o.len  = 2'd2;
      end else begin
         extract_o.inst = {16'h0000, win_i[0]};
         extract_o.len  = 2'd1;
      end
      // A 32-bit instruction with only its low half present is held back.
      extract_o.valid = (avail_i >= {2'b00, extract_o.len});
   end

endmodule

// File: rtl/fetch_align_buffer.sv
// -----------------------------------------------------------------------------
// fetch_align_buffer
// Response side of the fetch path. Queues halfwords of 64-bit I-cache beats,
// presents up to two RV32IC instructions per cycle to Decode, reports the
// consumed byte count as a PC_PLUS code and owns NowPC of the presented pair.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   Icache_Valid/Data incoming aligned 8-byte beat, hw0 = bits[15:0]
//   Icache_Ready      beat can be taken (registered occupancy <= 4)
//   Flush/Flush_PC    redirect; clears the queue and reloads NowPC
//   Decode_Ready      decode takes whatever is presented this cycle
//   Align_Inst0/1     presented instructions with their valid flags
//   Align_NowPC       PC of Align_Inst0
//   Decode_NextPC     PC_PLUS code of bytes consumed this cycle
// -----------------------------------------------------------------------------
module fetch_align_buffer #(
   parameter int                    ADDR_WIDTH    = fetch_align_buffer_pkg::ADDR_WIDTH,
   parameter int                    PC_PLUS_WIDTH = fetch_align_buffer_pkg::PC_PLUS_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] START_PC      = fetch_align_buffer_pkg::START_PC
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     Icache_Valid,
   input  logic [63:0]              Icache_Data,
   output logic                     Icache_Ready,
   input  logic                     Flush,
   input  logic [ADDR_WIDTH-1:0]    Flush_PC,
   input  logic                     Decode_Ready,
   output logic [31:0]              Align_Inst0,
   output logic                     Align_Inst0Valid,
   output logic [31:0]              Align_Inst1,
   output logic                     Align_Inst1Valid,
   output logic [ADDR_WIDTH-1:0]    Align_NowPC,
   output logic [PC_PLUS_WIDTH-1:0] Decode_NextPC
);

   import fetch_align_buffer_pkg::*;

   // Queue state
   logic [15:0]           queue_q [QUEUE_DEPTH];
   logic [15:0]           queue_d [QUEUE_DEPTH];
   logic [2:0]            head_q, head_d;
   logic [3:0]            count_q, count_d;
   logic [ADDR_WIDTH-1:0] now_pc_q, now_pc_d;
   logic [1:0]            skip_q, skip_d;

   // Extraction / handshake
   logic [3:0][15:0]      beat_hw_s;
   logic [3:0][15:0]      win0_s;
   logic [3:0][15:0]      win1_s;
   logic [3:0]            avail1_s;
   extract_t              ext0_s;
   extract_t              ext1_s;
   logic [2:0]            consume_hw_s;
   logic [2:0]            append_hw_s;
   logic [2:0]            tail_s;
   logic                  accept_s;
   // Redirect targets are halfword aligned, so bit 0 carries no information.
   logic                  unused_flush_pc_lsb_s;

   assign unused_flush_pc_lsb_s = Flush_PC[0];
   assign beat_hw_s             = Icache_Data;

   // Window for the first instruction, starting at the head.
   always_comb begin
      win0_s = '0;
      for (int i = 0; i < HW_PER_BEAT; i++) begin
         win0_s[i] = queue_q[head_q + 3'(i)];
      end
   end

   align_extract u_extract0 (
      .win_i     (win0_s),
      .avail_i   (count_q),
      .extract_o (ext0_s)
   );

   // Window for the second instruction, starting right after the first.
   // With no valid first instruction the second sees an empty queue.
   always_comb begin
      win1_s = '0;
      for (int i = 0; i < HW_PER_BEAT; i++) begin
         win1_s[i] = queue_q[head_q + {1'b0, ext0_s.len} + 3'(i)];
      end
      if (ext0_s.valid) begin
         avail1_s = count_q - {2'b00, ext0_s.len};
      end else begin
         avail1_s = 4'd0;
      end
   end

   align_extract u_extract1 (
      .win_i     (win1_s),
      .avail_i   (avail1_s),
      .extract_o (ext1_s)
   );

   // Halfwords consumed by Decode this cycle; nothing is consumed on a flush.
   always_comb begin
      consume_hw_s = 3'd0;
      if (Decode_Ready && !Flush) begin
         if (ext0_s.valid) begin
            consume_hw_s = {1'b0, ext0_s.len};
         end else begin
            consume_hw_s = 3'd0;
         end
         if (ext1_s.valid) begin
            consume_hw_s = consume_hw_s + {1'b0, ext1_s.len};
         end else begin
            consume_hw_s = consume_hw_s;
         end
      end else begin
         consume_hw_s = 3'd0;
      end
   end

   // Beat acceptance: ready depends only on registered occupancy, and a beat
   // arriving together with a flush belongs to the old path and is dropped.
   always_comb begin
      accept_s    = Icache_Valid && Icache_Ready && !Flush;
      tail_s      = head_q + count_q[2:0];
      if (accept_s) begin
         append_hw_s = 3'd4 - {1'b0, skip_q};
      end else begin
         append_hw_s = 3'd0;
      end
   end

   // Queue write: halfwords skip..3 of the beat land at tail, tail+1, ...
   always_comb begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         queue_d[i] = queue_q[i];
      end
      for (int j = 0; j < HW_PER_BEAT; j++) begin
         if (accept_s && (2'(j) >= skip_q)) begin
            queue_d[tail_s + 3'(j) - {1'b0, skip_q}] = beat_hw_s[j];
         end else begin
            queue_d[0] = queue_d[0];
         end
      end
   end

   // Pointer, occupancy, PC and skip next-state; a flush overrides everything.
   always_comb begin
      head_d   = head_q;
      count_d  = count_q;
      now_pc_d = now_pc_q;
      skip_d   = skip_q;
      if (Flush) begin
         head_d   = 3'd0;
         count_d  = 4'd0;
         now_pc_d = Flush_PC;
         skip_d   = Flush_PC[2:1];
      end else begin
         head_d   = head_q + consume_hw_s;
         count_d  = count_q - {1'b0, consume_hw_s} + {1'b0, append_hw_s};
         now_pc_d = now_pc_q + ADDR_WIDTH'({consume_hw_s, 1'b0});
         if (accept_s) begin
            skip_d = 2'b00;
         end else begin
            skip_d = skip_q;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            queue_q[i] <= 16'h0000;
         end
         head_q   <= 3'd0;
         count_q  <= 4'd0;
         now_pc_q <= START_PC;
         skip_q   <= START_PC[2:1];
      end else begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            queue_q[i] <= queue_d[i];
         end
         head_q   <= head_d;
         count_q  <= count_d;
         now_pc_q <= now_pc_d;
         skip_q   <= skip_d;
      end
   end

   assign Icache_Ready     = (count_q <= 4'd4);
   assign Align_Inst0      = ext0_s.inst;
   assign Align_Inst0Valid = ext0_s.valid;
   assign Align_Inst1      = ext1_s.inst;
   assign Align_Inst1Valid = ext1_s.valid;
   assign Align_NowPC      = now_pc_q;
   assign Decode_NextPC    = PC_PLUS_WIDTH'(pc_plus_encode(consume_hw_s));

endmodule

// File: tb/tb_fetch_align_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_align_buffer
// Directed stimulus with hand-computed expectations. Every instruction that is
// expected to reach Decode is queued with its PC; a monitor pops one entry per
// instruction Decode takes and compares word and PC. Cycle-level outputs
// (valid flags, PC_PLUS codes, ready, NowPC) are checked directly.
// -----------------------------------------------------------------------------
module tb_fetch_align_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        Icache_Valid;
   logic [63:0] Icache_Data;
   logic        Icache_Ready;
   logic        Flush;
   logic [31:0] Flush_PC;
   logic        Decode_Ready;
   logic [31:0] Align_Inst0;
   logic        Align_Inst0Valid;
   logic [31:0] Align_Inst1;
   logic        Align_Inst1Valid;
   logic [31:0] Align_NowPC;
   logic [2:0]  Decode_NextPC;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   fetch_align_buffer dut (
      .clk              (clk),
      .rst              (rst),
      .Icache_Valid     (Icache_Valid),
      .Icache_Data      (Icache_Data),
      .Icache_Ready     (Icache_Ready),
      .Flush            (Flush),
      .Flush_PC         (Flush_PC),
      .Decode_Ready     (Decode_Ready),
      .Align_Inst0      (Align_Inst0),
      .Align_Inst0Valid (Align_Inst0Valid),
      .Align_Inst1      (Align_Inst1),
      .Align_Inst1Valid (Align_Inst1Valid),
      .Align_NowPC      (Align_NowPC),
      .Decode_NextPC    (Decode_NextPC)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_inst(input logic [31:0] inst, input logic [31:0] pc);
      exp_t e;
      e.inst = inst;
      e.pc   = pc;
      sb_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every instruction Decode takes must match the next expected one.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && !Flush && Decode_Ready) begin
         if (Align_Inst1Valid && !Align_Inst0Valid) begin
            checks++;
            errors++;
            $display("FAIL inst1_without_inst0: inst1 %0h", Align_Inst1);
         end
         if (Align_Inst0Valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL inst0_unexpected: got %0h with no expected entry", Align_Inst0);
            end else begin
               e = sb_q.pop_front();
               chk("sb_inst0", {32'h0, Align_Inst0}, {32'h0, e.inst});
               chk("sb_pc0", {32'h0, Align_NowPC}, {32'h0, e.pc});
            end
         end
         if (Align_Inst1Valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL inst1_unexpected: got %0h with no expected entry", Align_Inst1);
            end else begin
               e = sb_q.pop_front();
               chk("sb_inst1", {32'h0, Align_Inst1}, {32'h0, e.inst});
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic done;
      logic taken;
      rst          = 1'b1;
      Icache_Valid = 1'b0;
      Icache_Data  = 64'h0;
      Flush        = 1'b0;
      Flush_PC     = 32'h0;
      Decode_Ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      // 1: reset state
      chk("rst_nowpc", {32'h0, Align_NowPC}, 64'h8000_0000);
      chk("rst_v0", {63'h0, Align_Inst0Valid}, 64'h0);
      chk("rst_v1", {63'h0, Align_Inst1Valid}, 64'h0);
      chk("rst_nextpc", {61'h0, Decode_NextPC}, 64'h0);
      chk("rst_ready", {63'h0, Icache_Ready}, 64'h1);

      // 2: two 32-bit instructions in one beat
      step();
      Icache_Valid = 1'b1;
      Icache_Data  = {32'h0010_0093, 32'h0000_0013};
      Decode_Ready = 1'b1;
      expect_inst(32'h0000_0013, 32'h8000_0000);
      expect_inst(32'h0010_0093, 32'h8000_0004);
      #1;
      chk("t2_latency", {63'h0, Align_Inst0Valid}, 64'h0);
      step();
      Icache_Valid = 1'b0;
      #1;
      chk("t2_v0", {63'h0, Align_Inst0Valid}, 64'h1);
      chk("t2_v1", {63'h0, Align_Inst1Valid}, 64'h1);
      chk("t2_nextpc", {61'h0, Decode_NextPC}, 64'h4);
      step();
      #1;
      chk("t2_nowpc", {32'h0, Align_NowPC}, 64'h8000_0008);
      chk("t2_empty_nextpc", {61'h0, Decode_NextPC}, 64'h0);

      // 3: RVC + 32-bit + RVC
      step();
      Icache_Valid = 1'b1;
      Icache_Data  = {16'h4585, 16'h0000, 16'h0013, 16'h4501};
      expect_inst(32'h0000_4501, 32'h8000_0008);
      expect_inst(32'h0000_0013, 32'h8000_000A);
      expect_inst(32'h0000_4585, 32'h8000_000E);
      step();
      Icache_Valid = 1'b0;
      #1;
      chk("t3_nextpc6", {61'h0, Decode_NextPC}, 64'h3);
      step();
      #1;
      chk("t3_nextpc2", {61'h0, Decode_NextPC}, 64'h1);
      chk("t3_single", {63'h0, Align_Inst1Valid}, 64'h0);
      step();
      #1;
      chk("t3_nowpc", {32'h0, Align_NowPC}, 64'h8000_0010);

      // 4: 32-bit instruction split across two beats
      step();
      Icache_Valid = 1'b1;
      Icache_Data  = {16'h0093, 16'h4585, 16'h4501, 16'h4505};
      expect_inst(32'h0000_4505, 32'h8000_0010);
      expect_inst(32'h0000_4501, 32'h8000_0012);
      expect_inst(32'h0000_4585, 32'h8000_0014);
      expect_inst(32'h0010_0093, 32'h8000_0016);
      expect_inst(32'h0000_4505, 32'h8000_001A);
      expect_inst(32'h0000_0013, 32'h8000_001C);
      step();
      Icache_Valid = 1'b0;
      #1;
      chk("t4_nextpc4", {61'h0, Decode_NextPC}, 64'h2);
      step();
      #1;
      chk("t4_nextpc2", {61'h0, Decode_NextPC}, 64'h1);
      step();
      Icache_Valid = 1'b1;
      Icache_Data  = {16'h0000, 16'h0013, 16'h4505, 16'h0010};
      #1;
      chk("t4_partial_held", {63'h0, Align_Inst0Valid}, 64'h0);
      chk("t4_partial_nextpc", {61'h0, Decode_NextPC}, 64'h0);
      step();
      Icache_Valid = 1'b0;
      #1;
      chk("t4_joined_nextpc6", {61'h0, Decode_NextPC}, 64'h3);
      step();
      #1;
      chk("t4_nextpc4b", {61'h0, Decode_NextPC}, 64'h2);
      step();
      #1;
      chk("t4_nowpc", {32'h0, Align_NowPC}, 64'h8000_0020);
      chk("t4_drained", {63'h0, Align_Inst0Valid}, 64'h0);

      // 5: flush discards queued and in-flight data
      step();
      Decode_Ready = 1'b0;
      Icache_Valid = 1'b1;
      Icache_Data  = {4{16'h4501}};
      step();
      Icache_Valid = 1'b0;
      #1;
      chk("t5_stalled_valid", {63'h0, Align_Inst0Valid}, 64'h1);
      chk("t5_stalled_nextpc", {61'h0, Decode_NextPC}, 64'h0);
      step();
      Flush        = 1'b1;
      Flush_PC     = 32'h8000_0106;
      Icache_Valid = 1'b1;
      Icache_Data  = {4{16'h4509}};
      Decode_Ready = 1'b1;
      #1;
      chk("t5_flush_nextpc", {61'h0, Decode_NextPC}, 64'h0);
      step();
      Flush        = 1'b0;
      Icache_Valid = 1'b0;
      #1;
      chk("t5_cleared", {63'h0, Align_Inst0Valid}, 64'h0);
      chk("t5_nowpc", {32'h0, Align_NowPC}, 64'h8000_0106);
      step();
      Icache_Valid = 1'b1;
      Icache_Data  = {16'h4585, 16'h4001, 16'h4001, 16'h4001};
      expect_inst(32'h0000_4585, 32'h8000_0106);
      #1;
      chk("t5_ready", {63'h0, Icache_Ready}, 64'h1);
      step();
      Icache_Valid = 1'b0;
      #1;
      chk("t5_only_hw3", {63'h0, Align_Inst1Valid}, 64'h0);
      chk("t5_nextpc2", {61'h0, Decode_NextPC}, 64'h1);
      step();
      #1;
      chk("t5_nowpc_after", {32'h0, Align_NowPC}, 64'h8000_0108);

      // 6: fill to 8 halfwords under back-pressure, then drain
      step();
      Decode_Ready = 1'b0;
      Icache_Valid = 1'b1;
      Icache_Data  = {16'h400d, 16'h4009, 16'h4005, 16'h4001};
      for (int k = 0; k < 12; k++) begin
         expect_inst(32'h0000_4001 + 32'(4 * k), 32'h8000_0108 + 32'(2 * k));
      end
      step();
      Icache_Data  = {16'h401d, 16'h4019, 16'h4015, 16'h4011};
      step();
      Icache_Data  = {16'h402d, 16'h4029, 16'h4025, 16'h4021};
      #1;
      chk("t6_full_ready", {63'h0, Icache_Ready}, 64'h0);
      chk("t6_full_nextpc", {61'h0, Decode_NextPC}, 64'h0);
      chk("t6_full_valid", {63'h0, Align_Inst0Valid}, 64'h1);
      step();
      #1;
      chk("t6_still_full", {63'h0, Icache_Ready}, 64'h0);
      step();
      Decode_Ready = 1'b1;
      #1;
      chk("t6_release_nextpc", {61'h0, Decode_NextPC}, 64'h2);
      done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
         taken = Icache_Valid && Icache_Ready;
         step();
         if (taken) begin
            Icache_Valid = 1'b0;
         end
         #1;
         if (!Icache_Valid && !Align_Inst0Valid) begin
            done = 1'b1;
         end
      end
      chk("t6_drain_bound", {63'h0, done}, 64'h1);
      chk("t6_nowpc", {32'h0, Align_NowPC}, 64'h8000_0120);

      // 7: reset mid-operation discards the queue
      step();
      Decode_Ready = 1'b0;
      Icache_Valid = 1'b1;
      Icache_Data  = {4{16'h4001}};
      step();
      Icache_Valid = 1'b0;
      #1;
      chk("t7_loaded", {63'h0, Align_Inst0Valid}, 64'h1);
      rst = 1'b1;
      #1;
      chk("t7_rst_valid", {63'h0, Align_Inst0Valid}, 64'h0);
      chk("t7_rst_nowpc", {32'h0, Align_NowPC}, 64'h8000_0000);
      chk("t7_rst_ready", {63'h0, Icache_Ready}, 64'h1);
      step();
      rst = 1'b0;
      #1;
      chk("t7_after_rst", {63'h0, Align_Inst0Valid}, 64'h0);

      step();
      chk("sb_empty", 64'(sb_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
